// File: rtl/cmd_seq_chk.sv
// cmd_seq_chk: queued command sequencer/checker for the Knight's Tour UART link.
// Holds up to DEPTH {cmd, expected resp} pairs, issues each over send_cmd/cmd_sent,
// then checks the response with per-phase timeouts.
// Build option: define CMDSEQ_STOP_ON_ERR_EN to end a run at the first error and keep
// the remaining entries queued; otherwise the failing entry is dropped and the run continues.
module cmd_seq_chk #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CMD_W  = 16,
    parameter int unsigned RESP_W = 8,
    parameter int unsigned TMO_W  = 26
) (
    input  logic                   clk,
    input  logic                   RST_n,
    input  logic                   push,
    input  logic [CMD_W-1:0]       push_cmd,
    input  logic [RESP_W-1:0]      push_exp,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TMO_W-1:0]       tmo_sent,
    input  logic [TMO_W-1:0]       tmo_resp,
    output logic [CMD_W-1:0]       cmd,
    output logic                   send_cmd,
    input  logic                   cmd_sent,
    input  logic                   resp_rdy,
    input  logic [RESP_W-1:0]      resp,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [$clog2(DEPTH):0] err_idx,
    output logic [$clog2(DEPTH):0] pass_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef CMDSEQ_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SENT_TMO = 2'b01;
    localparam logic [1:0] ERR_RESP_TMO = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Queue storage and bookkeeping
    logic [CMD_W-1:0]  mem_cmd [DEPTH];
    logic [RESP_W-1:0] mem_exp [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop;

    // Per-command datapath
    logic [RESP_W-1:0] exp_q, exp_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              early_q, early_d;
    logic [TMO_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  run_pos_q, run_pos_d;

    // Next values of the registered outputs
    logic [CMD_W-1:0]  cmd_d;
    logic              send_d, done_d, busy_d, full_d, empty_d, err_d;
    logic [1:0]        err_code_d;
    logic [CNT_W-1:0]  err_idx_d, pass_cnt_d;

    logic              sent_tmo, resp_tmo, match;
    logic              fail;
    logic [1:0]        fail_code;

    assign sent_tmo = (tmo_sent != '0) && (timer_q == tmo_sent);
    assign resp_tmo = (tmo_resp != '0) && (timer_q == tmo_resp);
    assign match    = (resp_q == exp_q);

    // Queue handshakes: abort flushes and beats any push; a pop frees room for a push at full
    assign pop     = (state_q == S_POP) && !abort;
    assign push_ok = push && !abort && ((count_q != CNT_W'(DEPTH)) || pop);

    // Queue occupancy next value
    always_comb begin
        count_d = count_q;
        if (abort) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue pointers and count
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Queue storage write (no reset needed: entries are only read once written)
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_cmd[wr_ptr_q] <= push_cmd;
            mem_exp[wr_ptr_q] <= push_exp;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; errors either end the run or move on to the next entry
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = empty ? S_DONE : S_POP;
            end
            S_POP:  state_d = S_SEND;
            S_SEND: state_d = S_WAIT_SENT;
            S_WAIT_SENT: begin
                if (cmd_sent) begin
                    state_d = (early_q || resp_rdy) ? S_CHECK : S_WAIT_RESP;
                end else if (sent_tmo) begin
                    state_d = (STOP_ON_ERR || empty) ? S_DONE : S_POP;
                end
            end
            S_WAIT_RESP: begin
                if (resp_rdy) begin
                    state_d = S_CHECK;
                end else if (resp_tmo) begin
                    state_d = (STOP_ON_ERR || empty) ? S_DONE : S_POP;
                end
            end
            S_CHECK: begin
                if (match || !STOP_ON_ERR) begin
                    state_d = empty ? S_DONE : S_POP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Output and datapath next values, computed from current state and the chosen next state
    always_comb begin
        cmd_d      = cmd;
        exp_d      = exp_q;
        resp_d     = resp_q;
        early_d    = early_q;
        timer_d    = '0;
        run_pos_d  = run_pos_q;
        err_d      = err;
        err_code_d = err_code;
        err_idx_d  = err_idx;
        pass_cnt_d = pass_cnt;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        send_d     = (state_d == S_SEND);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        full_d     = (count_d == CNT_W'(DEPTH));
        empty_d    = (count_d == '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    err_idx_d  = '0;
                    pass_cnt_d = '0;
                    run_pos_d  = '0;
                end
            end
            S_POP: begin
                cmd_d   = mem_cmd[rd_ptr_q];
                exp_d   = mem_exp[rd_ptr_q];
                early_d = 1'b0;
            end
            S_WAIT_SENT: begin
                if (resp_rdy) begin
                    resp_d  = resp;
                    early_d = 1'b1;
                end
                if (!cmd_sent && sent_tmo) begin
                    fail      = 1'b1;
                    fail_code = ERR_SENT_TMO;
                end
            end
            S_WAIT_RESP: begin
                if (resp_rdy) begin
                    resp_d = resp;
                end else if (resp_tmo) begin
                    fail      = 1'b1;
                    fail_code = ERR_RESP_TMO;
                end
            end
            S_CHECK: begin
                if (match) begin
                    pass_cnt_d = pass_cnt + CNT_W'(1);
                end else begin
                    fail      = 1'b1;
                    fail_code = ERR_MISMATCH;
                end
            end
            default: ;
        endcase

        // Every completed command (pass or fail) advances the run position
        if (fail || (state_q == S_CHECK)) run_pos_d = run_pos_q + CNT_W'(1);

        // Only the first error of a run is recorded
        if (fail && !err) begin
            err_d      = 1'b1;
            err_code_d = fail_code;
            err_idx_d  = run_pos_q;
        end

        // Timer restarts on every entry into a wait state
        if ((state_d == state_q) &&
            ((state_q == S_WAIT_SENT) || (state_q == S_WAIT_RESP))) begin
            timer_d = timer_q + TMO_W'(1);
        end

        if (abort) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            err_idx_d  = '0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            cmd       <= '0;
            send_cmd  <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_idx   <= '0;
            pass_cnt  <= '0;
            exp_q     <= '0;
            resp_q    <= '0;
            early_q   <= 1'b0;
            timer_q   <= '0;
            run_pos_q <= '0;
        end else begin
            cmd       <= cmd_d;
            send_cmd  <= send_d;
            full      <= full_d;
            empty     <= empty_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= err_code_d;
            err_idx   <= err_idx_d;
            pass_cnt  <= pass_cnt_d;
            exp_q     <= exp_d;
            resp_q    <= resp_d;
            early_q   <= early_d;
            timer_q   <= timer_d;
            run_pos_q <= run_pos_d;
        end
    end

endmodule
